// File: rtl/multiword_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// multiword_add_seq_pkg
// Shared definitions for the word-serial multiword adder:
//   - default operand width and word-slice width
//   - derived word count and word-index width for the defaults
//   - FSM state encoding (IDLE / ADD / DONE)
//   - helper that sizes the word index for any word count
// No ports (package).
// ---------------------------------------------------------------------------
package multiword_add_seq_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int WORD_WIDTH_DEFAULT = 4;

    // Index width never drops to zero, even for a single-word configuration.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int WORDS     = DATA_WIDTH_DEFAULT / WORD_WIDTH_DEFAULT;
    localparam int IDX_WIDTH = idx_width(WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ripple_adder_core.sv
// ---------------------------------------------------------------------------
// ripple_adder_core
// Purely combinational WIDTH-bit ripple-carry adder built from full-adder
// cells. Used by the sequencer to add one word slice per cycle.
// Ports:
//   a, b  input  [WIDTH-1:0]  addend words
//   ci    input               carry into bit 0
//   s     output [WIDTH-1:0]  sum word
//   co    output              carry out of the top bit
// ---------------------------------------------------------------------------
module ripple_adder_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] carry;

    assign carry[0] = ci;

    // One full-adder cell per bit; carry ripples from bit 0 upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign co = carry[WIDTH];

endmodule

// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
// Word-serial adder: accepts two DATA_WIDTH operands plus a carry-in, then
// adds them WORD_WIDTH bits per cycle (least significant word first) using a
// single ripple_adder_core, and presents the sum with a valid/ready handshake.
// Ports:
//   clk     input                     rising-edge clock
//   rst_n   input                     asynchronous active-low reset
//   in_a    input  [DATA_WIDTH-1:0]   operand A
//   in_b    input  [DATA_WIDTH-1:0]   operand B
//   in_ci   input                     carry into the least significant word
//   in_vld  input                     operand valid
//   in_rd   output                    operand ready (IDLE and out of reset)
//   out_s   output [DATA_WIDTH-1:0]   sum
//   out_co  output                    carry out of the most significant word
//   out_vld output                    result valid
//   out_rd  input                     result ready
// ---------------------------------------------------------------------------
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_ci,
    input  logic                  in_vld,
    output logic                  in_rd,
    output logic [DATA_WIDTH-1:0] out_s,
    output logic                  out_co,
    output logic                  out_vld,
    input  logic                  out_rd
);

    localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_W     = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // Refuse to elaborate a configuration that does not split into whole words.
    if ((WORD_WIDTH < 1) || (DATA_WIDTH % WORD_WIDTH != 0) || (NUM_WORDS < 1)) begin : g_bad_cfg
        $error("multiword_add_seq: DATA_WIDTH must be a positive multiple of WORD_WIDTH");
    end

    logic [1:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] sum_reg;
    logic                  carry;

    logic [WORD_WIDTH-1:0] word_a;
    logic [WORD_WIDTH-1:0] word_b;
    logic [WORD_WIDTH-1:0] word_s;
    logic                  word_co;

    // Select the current word of each latched operand for the shared adder.
    assign word_a = a_reg[idx*WORD_WIDTH +: WORD_WIDTH];
    assign word_b = b_reg[idx*WORD_WIDTH +: WORD_WIDTH];

    ripple_adder_core #(
        .WIDTH (WORD_WIDTH)
    ) u_core (
        .a  (word_a),
        .b  (word_b),
        .ci (carry),
        .s  (word_s),
        .co (word_co)
    );

    // Sequencer: latch operands in IDLE, walk the words in ADD, hold the
    // result in DONE until it is consumed. The carry register doubles as the
    // inter-word carry during ADD and as the final carry-out in DONE, and is
    // reloaded from in_ci on every acceptance so no carry leaks across ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_vld) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b;
                        carry   <= in_ci;
                        sum_reg <= '0;
                        idx     <= '0;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    sum_reg[idx*WORD_WIDTH +: WORD_WIDTH] <= word_s;
                    carry <= word_co;
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_rd) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is forced low while reset is held so nothing is offered as taken.
    assign in_rd   = rst_n && (state == ST_IDLE);
    assign out_vld = (state == ST_DONE);
    assign out_s   = sum_reg;
    assign out_co  = carry;

endmodule

// File: tb/tb_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_seq
// Self-checking bench for multiword_add_seq (16-bit operands, 4-bit words).
// A cycle-level behavioural model tracks what the handshake and result must
// be from plain arithmetic; directed cases pin literal results and latency,
// and a randomized phase exercises arbitrary operands and backpressure.
// ---------------------------------------------------------------------------
module tb_multiword_add_seq;

    localparam int DW    = 16;
    localparam int WW    = 4;
    localparam int WORDS = DW / WW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_ci;
    logic          in_vld;
    logic          in_rd;
    logic [DW-1:0] out_s;
    logic          out_co;
    logic          out_vld;
    logic          out_rd;

    int n_vec = 0;
    int n_bad = 0;

    multiword_add_seq #(
        .DATA_WIDTH (DW),
        .WORD_WIDTH (WW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_a    (in_a),
        .in_b    (in_b),
        .in_ci   (in_ci),
        .in_vld  (in_vld),
        .in_rd   (in_rd),
        .out_s   (out_s),
        .out_co  (out_co),
        .out_vld (out_vld),
        .out_rd  (out_rd)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison helper; every check in the bench goes through here.
    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model and compare process. Sampled 3 time units after each
    // falling edge, when inputs are settled and outputs are stable, and it
    // predicts what the next rising edge will do. The model knows only the
    // observable rules: accept when idle, result appears WORDS cycles later,
    // equals a+b+ci, and is held until consumed.
    initial begin : model
        int            m_phase;
        int            m_cnt;
        logic [DW:0]   m_exp;
        m_phase = 0;
        m_cnt   = 0;
        m_exp   = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                compareValue("rst_out_vld", 32'(out_vld), 32'd0);
                compareValue("rst_out_s",   32'(out_s),   32'd0);
                compareValue("rst_out_co",  32'(out_co),  32'd0);
                compareValue("rst_in_rd",   32'(in_rd),   32'd0);
                m_phase = 0;
            end else begin
                case (m_phase)
                    0: begin
                        compareValue("idle_in_rd",   32'(in_rd),   32'd1);
                        compareValue("idle_out_vld", 32'(out_vld), 32'd0);
                        if (in_vld) begin
                            m_exp   = {1'b0, in_a} + {1'b0, in_b} + {{DW{1'b0}}, in_ci};
                            m_cnt   = WORDS;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        compareValue("busy_in_rd",   32'(in_rd),   32'd0);
                        compareValue("busy_out_vld", 32'(out_vld), 32'd0);
                        m_cnt--;
                        if (m_cnt == 0) m_phase = 2;
                    end
                    default: begin
                        compareValue("done_out_vld", 32'(out_vld), 32'd1);
                        compareValue("done_in_rd",   32'(in_rd),   32'd0);
                        compareValue("done_out_s",   32'(out_s),   32'(m_exp[DW-1:0]));
                        compareValue("done_out_co",  32'(out_co),  32'(m_exp[DW]));
                        if (out_rd) m_phase = 0;
                    end
                endcase
            end
        end
    end

    // Offer an operand and hold in_vld until it is taken. Called and returns
    // 1 time unit after a falling edge; wait_cycles reports how many edges
    // passed before acceptance.
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic ci, output int wait_cycles);
        logic accepted;
        accepted    = 1'b0;
        wait_cycles = 0;
        in_a   = a;
        in_b   = b;
        in_ci  = ci;
        in_vld = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            #1;
            if (in_rd) accepted = 1'b1;
            else       wait_cycles++;
            @(negedge clk);
            #1;
        end
        in_vld = 1'b0;
        if (!accepted) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL accept_timeout: got in_rd=0 for 50 cycles, want acceptance");
        end
    endtask

    // Wait for the result right after an acceptance, check latency and value
    // against literals, hold backpressure for extra cycles, then consume.
    task automatic checkOutput(input logic [DW-1:0] exp_s, input logic exp_co, input int hold);
        int   lat;
        logic got;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (out_vld) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                lat++;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL result_timeout: got out_vld=0 for 60 cycles, want 1");
        end else begin
            compareValue("latency", 32'(lat),    32'(WORDS));
            compareValue("out_s",   32'(out_s),  32'(exp_s));
            compareValue("out_co",  32'(out_co), 32'(exp_co));
            @(negedge clk);
            #1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
            end
            compareValue("held_out_s", 32'(out_s), 32'(exp_s));
            out_rd = 1'b1;
            @(negedge clk);
            #1;
            out_rd = 1'b0;
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases followed by randomized traffic.
    initial begin : stim
        int wc;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic          rc;
        logic [DW:0]   rsum;

        rst_n  = 1'b0;
        in_a   = '0;
        in_b   = '0;
        in_ci  = 1'b0;
        in_vld = 1'b0;
        out_rd = 1'b0;

        // Reset held for 3 cycles, outputs quiet, ready gated.
        repeat (3) @(negedge clk);
        #2;
        compareValue("reset_out_vld", 32'(out_vld), 32'd0);
        compareValue("reset_out_s",   32'(out_s),   32'h0000);
        compareValue("reset_out_co",  32'(out_co),  32'd0);
        compareValue("reset_in_rd",   32'(in_rd),   32'd0);
        #9;
        rst_n = 1'b1;
        #1;
        compareValue("release_in_rd", 32'(in_rd), 32'd1);
        @(negedge clk);
        #1;

        $display("[TB] basic add 0x1234+0x4321");
        applyStimulus(16'h1234, 16'h4321, 1'b0, wc);
        checkOutput(16'h5555, 1'b0, 0);

        $display("[TB] full carry ripple 0xFFFF+0x0000+1");
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, wc);
        checkOutput(16'h0000, 1'b1, 0);

        // Backpressure: a new operand is offered while the result waits.
        $display("[TB] backpressure 0x00F0+0x0010");
        applyStimulus(16'h00F0, 16'h0010, 1'b0, wc);
        in_a   = 16'h1111;
        in_b   = 16'h0000;
        in_ci  = 1'b0;
        in_vld = 1'b1;
        checkOutput(16'h0100, 1'b0, 3);
        applyStimulus(16'h1111, 16'h0000, 1'b0, wc);
        compareValue("post_consume_accept_wait", 32'(wc), 32'd0);
        checkOutput(16'h1111, 1'b0, 0);

        // Reset two cycles into ADD aborts the operation.
        $display("[TB] reset during ADD");
        applyStimulus(16'hABCD, 16'h1234, 1'b1, wc);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        compareValue("abort_in_rd", 32'(in_rd),   32'd1);
        compareValue("abort_vld",   32'(out_vld), 32'd0);
        @(negedge clk);
        #1;
        applyStimulus(16'h0001, 16'h0002, 1'b0, wc);
        checkOutput(16'h0003, 1'b0, 0);

        $display("[TB] back-to-back, no stale carry");
        applyStimulus(16'h8000, 16'h8000, 1'b0, wc);
        checkOutput(16'h0000, 1'b1, 0);
        applyStimulus(16'h0001, 16'h0001, 1'b0, wc);
        checkOutput(16'h0002, 1'b0, 0);

        $display("[TB] randomized operands");
        for (int n = 0; n < 40; n++) begin
            ra   = DW'($urandom);
            rb   = DW'($urandom);
            rc   = 1'($urandom_range(0, 1));
            rsum = {1'b0, ra} + {1'b0, rb} + {{DW{1'b0}}, rc};
            applyStimulus(ra, rb, rc, wc);
            checkOutput(rsum[DW-1:0], rsum[DW], int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
